// File: rtl/buzzer_scheduler_if.sv
// Request-side bus of the buzzer scheduler: per-requester pulses,
// packed pattern fields and per-requester status back to the requesters.
interface buzzer_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 32,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*DUR_W-1:0] req_on;
    logic [NUM_REQ*DUR_W-1:0] req_off;
    logic [NUM_REQ*CNT_W-1:0] req_count;
    logic [NUM_REQ-1:0]       abort;
    logic [NUM_REQ-1:0]       busy;
    logic [NUM_REQ-1:0]       done;

    modport master (
        output req, req_on, req_off, req_count, abort,
        input  busy, done
    );

    modport slave (
        input  req, req_on, req_off, req_count, abort,
        output busy, done
    );
endinterface

// File: rtl/buzzer_scheduler.sv
// Round-robin sharing of one buzzer between NUM_REQ requesters, each
// playing an on/off/repeat beep pattern through continuous-mode enable.
module buzzer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 32,
    parameter int CNT_W   = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              resetn,
    buzzer_scheduler_if.slave bus,
    input  logic              mute,
    output logic              active,
    output logic [ID_W-1:0]   active_id,
    output logic              buz_enable,
    output logic [1:0]        buz_mode,
    output logic [31:0]       buz_duration_on,
    output logic [31:0]       buz_duration_off
);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] done;
    logic [DUR_W-1:0]   on_q  [NUM_REQ];
    logic [DUR_W-1:0]   off_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [DUR_W-1:0]   on_in [NUM_REQ];
    logic [CNT_W-1:0]   cnt_in[NUM_REQ];
    logic [DUR_W-1:0]   on_cnt;
    logic [DUR_W-1:0]   off_cnt;
    logic [CNT_W-1:0]   rep_cnt;
    logic [ID_W-1:0]    rr;
    logic [ID_W-1:0]    grant;
    logic               found;
    logic               play;
    logic               last;
    logic               abort_act;

    // Zero on-time and zero count both mean one, so fold that in at latch time
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            on_in[i]  = bus.req_on[i*DUR_W +: DUR_W];
            cnt_in[i] = bus.req_count[i*CNT_W +: CNT_W];
            if (on_in[i] == '0) on_in[i] = DUR_W'(1);
            if (cnt_in[i] == '0) cnt_in[i] = CNT_W'(1);
        end
    end

    always_comb begin
        busy = pending;
        if (active) busy[active_id] = 1'b1;
    end

    assign cand      = pending & ~bus.abort;
    assign abort_act = active && bus.abort[active_id];

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && cand[(int'(rr) + k) % NUM_REQ]) begin
                found = 1'b1;
                grant = ID_W'((int'(rr) + k) % NUM_REQ);
            end
        end
    end

    // Final cycle of a beep: on phase with no gap, or last gap cycle
    assign last = (state == ON && on_cnt == DUR_W'(1) && off_cnt == '0)
               || (state == OFF && off_cnt == DUR_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pending   <= '0;
            on_cnt    <= '0;
            off_cnt   <= '0;
            rep_cnt   <= '0;
            rr        <= ID_W'(NUM_REQ - 1);
            active    <= 1'b0;
            active_id <= '0;
            play      <= 1'b0;
            done      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                on_q[i]  <= '0;
                off_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            done <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.abort[i]) begin
                    pending[i] <= 1'b0;
                end else if (bus.req[i] && !busy[i]) begin
                    pending[i] <= 1'b1;
                    on_q[i]    <= on_in[i];
                    off_q[i]   <= bus.req_off[i*DUR_W +: DUR_W];
                    cnt_q[i]   <= cnt_in[i];
                end
            end
            unique case (state)
                IDLE: begin
                    if (found) begin
                        rr             <= grant;
                        active_id      <= grant;
                        active         <= 1'b1;
                        pending[grant] <= 1'b0;
                        on_cnt         <= on_q[grant];
                        off_cnt        <= off_q[grant];
                        rep_cnt        <= cnt_q[grant];
                        play           <= 1'b1;
                        state          <= ON;
                    end
                end
                ON: begin
                    if (on_cnt != DUR_W'(1)) begin
                        on_cnt <= on_cnt - DUR_W'(1);
                    end else if (off_cnt != '0) begin
                        play  <= 1'b0;
                        state <= OFF;
                    end
                end
                OFF: begin
                    if (off_cnt != DUR_W'(1))
                        off_cnt <= off_cnt - DUR_W'(1);
                end
                default: state <= IDLE;
            endcase
            if (last) begin
                if (rep_cnt > CNT_W'(1)) begin
                    rep_cnt <= rep_cnt - CNT_W'(1);
                    on_cnt  <= on_q[active_id];
                    off_cnt <= off_q[active_id];
                    play    <= 1'b1;
                    state   <= ON;
                end else begin
                    done[active_id] <= 1'b1;
                    active_id       <= '0;
                    active          <= 1'b0;
                    play            <= 1'b0;
                    state           <= IDLE;
                end
            end
            // Cancelling the served pattern ends it silently, no done
            if (abort_act) begin
                done      <= '0;
                active_id <= '0;
                active    <= 1'b0;
                play      <= 1'b0;
                state     <= IDLE;
            end
        end
    end

    assign bus.done         = done;
    assign bus.busy         = busy;
    assign buz_enable       = play & ~mute;
    assign buz_mode         = 2'b10;
    assign buz_duration_on  = '0;
    assign buz_duration_off = '0;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with a pattern-timeline model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_buzzer_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mute = 1'b0;
    logic        active;
    logic [1:0]  active_id;
    logic        buz_enable;
    logic [1:0]  buz_mode;
    logic [31:0] buz_duration_on;
    logic [31:0] buz_duration_off;

    int checks = 0;
    int errors = 0;

    buzzer_scheduler_if #(.NUM_REQ(4), .DUR_W(32), .CNT_W(8)) bus();

    buzzer_scheduler #(.NUM_REQ(4), .DUR_W(32), .CNT_W(8)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus              (bus),
        .mute             (mute),
        .active           (active),
        .active_id        (active_id),
        .buz_enable       (buz_enable),
        .buz_mode         (buz_mode),
        .buz_duration_on  (buz_duration_on),
        .buz_duration_off (buz_duration_off)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Model: a granted pattern is a timeline of count*(on+off) cycles;
    // tau is the position in it, enable is high in the first on of each period.
    bit [3:0]    m_pend = '0;
    bit [3:0]    m_done = '0;
    int unsigned m_on[4];
    int unsigned m_off[4];
    int unsigned m_cnt[4];
    bit          m_act = 1'b0;
    int          m_id = 0;
    int          m_rr = 3;
    longint      m_tau = 0;
    int unsigned m_con = 1;
    int unsigned m_coff = 0;
    int unsigned m_ccnt = 1;

    task automatic m_step();
        bit [3:0] bnow;
        bit [3:0] cand;
        longint   per;
        bit       found;
        int       g;
        if (!resetn) begin
            m_pend = '0;
            m_done = '0;
            m_act  = 1'b0;
            m_id   = 0;
            m_rr   = 3;
            m_tau  = 0;
            return;
        end
        bnow = m_pend;
        if (m_act) bnow[m_id] = 1'b1;
        cand   = m_pend & ~bus.abort;
        m_done = '0;
        if (m_act) begin
            per = longint'(m_con) + longint'(m_coff);
            if (bus.abort[m_id]) begin
                m_act = 1'b0;
            end else if (m_tau + 1 == longint'(m_ccnt) * per) begin
                m_act = 1'b0;
                m_done[m_id] = 1'b1;
            end else begin
                m_tau++;
            end
        end else begin
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && cand[(m_rr + k) % 4]) begin
                    found = 1'b1;
                    g = (m_rr + k) % 4;
                end
            end
            if (found) begin
                m_act = 1'b1;
                m_id = g;
                m_rr = g;
                m_tau = 0;
                m_con = m_on[g];
                m_coff = m_off[g];
                m_ccnt = m_cnt[g];
                m_pend[g] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.abort[i]) begin
                m_pend[i] = 1'b0;
            end else if (bus.req[i] && !bnow[i]) begin
                m_pend[i] = 1'b1;
                m_on[i] = bus.req_on[i*32 +: 32];
                m_off[i] = bus.req_off[i*32 +: 32];
                m_cnt[i] = 32'(bus.req_count[i*8 +: 8]);
                if (m_on[i] == 0) m_on[i] = 1;
                if (m_cnt[i] == 0) m_cnt[i] = 1;
            end
        end
    endtask

    initial begin
        bit [3:0] ebusy;
        bit       een;
        longint   per;
        forever begin
            @(posedge clk);
            m_step();
            #1;
            ebusy = m_pend;
            if (m_act) ebusy[m_id] = 1'b1;
            per = longint'(m_con) + longint'(m_coff);
            een = m_act && ((m_tau % per) < longint'(m_con)) && !mute;
            chk("m_active", 64'(active), 64'(m_act));
            chk("m_active_id", 64'(active_id), m_act ? 64'(m_id) : 64'd0);
            chk("m_busy", 64'(bus.busy), 64'(ebusy));
            chk("m_done", 64'(bus.done), 64'(m_done));
            chk("m_buz_enable", 64'(buz_enable), 64'(een));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        bus.req = '0;
        bus.abort = '0;
    endtask

    task automatic post(input int i, input int unsigned on,
                        input int unsigned off, input int unsigned cnt);
        bus.req[i] = 1'b1;
        bus.req_on[i*32 +: 32] = on;
        bus.req_off[i*32 +: 32] = off;
        bus.req_count[i*8 +: 8] = 8'(cnt);
    endtask

    initial begin
        logic [12:0] en_lit;
        logic [12:0] busy_lit;
        logic [12:0] done_lit;
        int          order[$];
        int          exp_ord[6];
        bit          prev;
        bit          seen2;
        bus.req = '0;
        bus.abort = '0;
        bus.req_on = '0;
        bus.req_off = '0;
        bus.req_count = '0;
        repeat (2) tick();
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_enable", 64'(buz_enable), 64'd0);
        chk("rst_mode", 64'(buz_mode), 64'd2);
        chk("rst_dur_on", 64'(buz_duration_on), 64'd0);
        chk("rst_dur_off", 64'(buz_duration_off), 64'd0);
        resetn = 1'b1;
        tick();

        // Round robin from reset pointer 3, then pointer left at 3
        exp_ord = '{0, 1, 2, 3, 0, 2};
        prev = 1'b0;
        for (int i = 0; i < 4; i++) post(i, 1, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (active && !prev) order.push_back(int'(active_id));
            prev = active;
        end
        post(0, 1, 1, 1);
        post(2, 1, 1, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (active && !prev) order.push_back(int'(active_id));
            prev = active;
        end
        chk("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk("rr_order", i < order.size() ? 64'(order[i]) : 64'hFF,
                64'(exp_ord[i]));
        repeat (3) tick();

        // on=3 off=2 count=2 on requester 1
        en_lit = 13'h039C;
        busy_lit = 13'h0FFE;
        done_lit = 13'h1000;
        post(1, 3, 2, 2);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t1_en", 64'(buz_enable), 64'(en_lit[k]));
            chk("t1_busy1", 64'(bus.busy[1]), 64'(busy_lit[k]));
            chk("t1_done1", 64'(bus.done[1]), 64'(done_lit[k]));
        end
        repeat (3) tick();

        // all-zero fields give a single enable cycle
        post(0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t3_en", 64'(buz_enable), 64'(k == 2));
            chk("t3_done0", 64'(bus.done[0]), 64'(k == 3));
        end
        repeat (3) tick();

        // abort active requester 2 in its second beep, 3 takes over
        seen2 = 1'b0;
        post(2, 10, 0, 3);
        post(3, 2, 1, 1);
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (bus.done[2]) seen2 = 1'b1;
            if (k == 15) begin
                chk("t4_en_before", 64'(buz_enable), 64'd1);
                bus.abort[2] = 1'b1;
            end
            if (k == 16) begin
                chk("t4_en_after", 64'(buz_enable), 64'd0);
                chk("t4_busy2", 64'(bus.busy[2]), 64'd0);
                chk("t4_active", 64'(active), 64'd0);
            end
            if (k == 17) begin
                chk("t4_id3", 64'(active_id), 64'd3);
                chk("t4_active3", 64'(active), 64'd1);
            end
            if (k == 20) chk("t4_done3", 64'(bus.done[3]), 64'd1);
        end
        chk("t4_no_done2", 64'(seen2), 64'd0);
        repeat (3) tick();

        // asynchronous reset in the middle of an on phase
        post(1, 8, 0, 1);
        repeat (4) tick();
        chk("t5_en_on", 64'(buz_enable), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t5_en_rst", 64'(buz_enable), 64'd0);
        chk("t5_busy_rst", 64'(bus.busy), 64'd0);
        chk("t5_active_rst", 64'(active), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        post(2, 1, 0, 1);
        post(0, 1, 0, 1);
        repeat (2) tick();
        chk("t5_first0", 64'(active_id), 64'd0);
        chk("t5_active0", 64'(active), 64'd1);
        repeat (10) tick();

        // muted pattern, re-request while busy ignored
        mute = 1'b1;
        post(0, 4, 0, 2);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) bus.abort[3] = 1'b1;
            if (k == 3) post(0, 1, 0, 1);
            chk("t6_en", 64'(buz_enable), 64'd0);
            chk("t6_done0", 64'(bus.done[0]), 64'(k == 10));
        end
        mute = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Shares the single board buzzer between NUM_REQ independent requesters, e.g. alarm, keypress feedback and status tones.
- Each requester posts a beep pattern: on time, off time and repeat count. The scheduler grants requests round-robin and times the pattern itself.
- It drives the buzzer block in continuous mode (mode 2'b10), in which the buzzer sounds while enable is high.
- It sits between software/status logic and the buzzer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DUR_W, 32, width of the on/off duration fields, in clk cycles.
- CNT_W, 8, width of the repeat-count field.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request pulse; parameters sampled on the same edge.
- req_on  in  NUM_REQ*DUR_W  packed on durations; slice i belongs to requester i.
- req_off  in  NUM_REQ*DUR_W  packed off durations.
- req_count  in  NUM_REQ*CNT_W  packed beep counts.
- abort  in  NUM_REQ  per-requester cancel pulse.
- mute  in  1  forces buz_enable low; timing is unaffected.
- busy  out  NUM_REQ  requester i is pending or being served.
- done  out  NUM_REQ  one-cycle pulse when requester i's pattern completes normally.
- active  out  1  a pattern is being played.
- active_id  out  $clog2(NUM_REQ)  index of the requester being served; 0 when idle.
- buz_enable  out  1  to buzzer enable.
- buz_mode  out  2  constant 2'b10.
- buz_duration_on  out  32  constant 0.
- buz_duration_off  out  32  constant 0.

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE, all pending/param registers 0, busy=0, done=0, active=0, active_id=0, buz_enable=0, rr pointer = NUM_REQ-1. Reset mid-pattern drops buz_enable immediately; no done pulse.
- Request latch: req[i]=1 with busy[i]=0 stores that slice's on/off/count into requester i's registers and sets pending[i]; busy[i]=1 from the next cycle. req[i] while busy[i]=1 is ignored; the first request is unchanged.
- Zero rules: on=0 is treated as 1, count=0 is treated as 1, off=0 means no gap.
- FSM states IDLE, ON, OFF.
- IDLE: if any pending bit is set, grant the first pending index searching from rr+1 upward with wrap. On that edge: rr<=grant, active_id<=grant, active<=1, pending[grant]<=0 (busy stays 1), on_cnt<=on, off_cnt<=off, rep_cnt<=count, state<=ON.
- Latency: req at edge t, then pending at t+1, then state ON at edge t+2. buz_enable follows state registered, so the buzzer output lags by a further 1 cycle inside the buzzer.
- ON: buz_enable=1 (unless mute) for exactly max(on,1) cycles. On the last cycle go to OFF if off>0; otherwise handle end-of-beep directly.
- OFF: buz_enable=0 for exactly off cycles.
- End of beep: if rep_cnt>1, decrement it, reload on_cnt/off_cnt and go to ON. Else: state<=IDLE, done[id]=1 for one cycle, busy[id]<=0, active<=0.
- The final off period is always played, giving a guaranteed gap before the next grant.
- IDLE with a pending request re-grants on the next edge, so there is 1 idle cycle between patterns.
- Abort of a pending requester: clear pending; busy drops next cycle; no done.
- Abort of the active requester: state<=IDLE, buz_enable=0 next cycle, busy/active cleared, no done. rr keeps the aborted index.
- Same-cycle req[i] and abort[i]: abort wins; the request is not latched.
- Abort of an idle requester: no effect.
- Same-edge completion of requester i and new req[i]: the request is ignored, because busy[i] is still 1 on that edge.
- Counters are saturating-free down-counters of DUR_W/CNT_W bits. Full-scale values (all ones) must play the full length with no wrap.
- mute only gates buz_enable; counters, done and busy are unchanged.

Test Plan:
- Single request, on=3, off=2, count=2, to requester 1 at cycle 0 -> buz_enable high cycles 2-4 and 7-9, low cycles 5-6 and 10-11; done[1] pulses at cycle 12; busy[1] high cycles 1-11.
- req=4'b1111 on one edge, each with on=1, off=1, count=1 -> served order 0,1,2,3 with active_id following. Then req=4'b0101 -> served order 0,2 (pointer at 3).
- on=0, off=0, count=0 -> exactly one buz_enable cycle, then done on the next cycle.
- Requester 2 playing on=10, count=3; abort[2] during the second beep -> buz_enable low next cycle, no done[2], busy[2]=0; pending requester 3 granted afterwards.
- resetn low mid-ON -> buz_enable, busy, active all 0 asynchronously. After release, a new request plays normally starting from index 0 priority.
- mute=1 throughout on=4, off=0, count=2 -> buz_enable stays 0, done pulses at the same cycle as unmuted. A req[0] repeated while busy is ignored, and the original parameters play.
